// File: rtl/bpu_btb.sv
// rtl/bpu_btb.sv - IF-stage branch predictor: direct-mapped BTB with 2-bit counters.
// EX outcomes train the table and raise the fetch redirect on a mispredict.
module bpu_btb #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_bj,
  input  logic        ex_uncond,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] lookup_cnt,
  output logic [31:0] mispred_cnt
);
  localparam int N = 1 << IDX_W;

  logic [N-1:0]     valid_q, valid_d;
  logic [1:0]       ctr_q [N];
  logic [1:0]       ctr_d [N];
  logic [TAG_W-1:0] tag_q [N];
  logic [TAG_W-1:0] tag_d [N];
  logic [31:0]      target_q [N];
  logic [31:0]      target_d [N];
  logic [31:0]      lookup_cnt_q, lookup_cnt_d;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];

  // Lookup sees only registered contents, so a same-cycle update is not bypassed.
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_valid && if_hit && ctr_q[if_idx][1];
    pred_target = pred_taken ? target_q[if_idx] : 32'd0;
  end

  always_comb begin
    redirect = 1'b0;
    if (ex_valid) begin
      if (ex_is_bj) begin
        redirect = (ex_taken != ex_pred_taken) ||
                   (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
      end else begin
        redirect = ex_pred_taken;
      end
    end
    redirect_pc = 32'd0;
    if (redirect) begin
      redirect_pc = (ex_is_bj && ex_taken) ? ex_target : ex_pc + 32'd4;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    if (ex_valid) begin
      if (ex_is_bj) begin
        if (ex_hit) begin
          if (ex_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
            target_d[ex_idx] = ex_target;
          end else if (ctr_q[ex_idx] != 2'b00) begin
            ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          valid_d[ex_idx]  = 1'b1;
          tag_d[ex_idx]    = ex_tag;
          target_d[ex_idx] = ex_target;
          ctr_d[ex_idx]    = ex_uncond ? 2'b11 : 2'b10;
        end
      end else if (ex_hit) begin
        valid_d[ex_idx] = 1'b0;
      end
    end

    lookup_cnt_d  = (if_valid && (lookup_cnt_q != 32'hFFFF_FFFF)) ?
                    lookup_cnt_q + 32'd1 : lookup_cnt_q;
    mispred_cnt_d = (redirect && (mispred_cnt_q != 32'hFFFF_FFFF)) ?
                    mispred_cnt_q + 32'd1 : mispred_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q       <= '0;
      lookup_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
      for (int i = 0; i < N; i++) ctr_q[i] <= 2'b01;
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      lookup_cnt_q  <= lookup_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Tag and target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign lookup_cnt  = lookup_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_bpu_btb.sv
// tb/tb_bpu_btb.sv - directed and randomized checks of bpu_btb against a table model.
module tb_bpu_btb;
  logic        clk = 1'b0;
  logic        resetn, if_valid, pred_taken, ex_valid, ex_is_bj, ex_uncond, ex_taken;
  logic        ex_pred_taken, redirect;
  logic [31:0] if_pc, pred_target, ex_pc, ex_target, ex_pred_target, redirect_pc;
  logic [31:0] lookup_cnt, mispred_cnt;

  always #5 clk = ~clk;

  bpu_btb dut (
    .clk(clk), .resetn(resetn), .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_bj(ex_is_bj), .ex_uncond(ex_uncond),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .redirect(redirect), .redirect_pc(redirect_pc),
    .lookup_cnt(lookup_cnt), .mispred_cnt(mispred_cnt)
  );

  int checks = 0;
  int failures = 0;

  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_lk, m_mp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic logic [25:0] tag_of(input logic [31:0] pc);
    return pc[31:6];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_lk = 32'd0;
    m_mp = 32'd0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int i;
    i  = idx_of(pc);
    tk = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    tg = tk ? m_tgt[i] : 32'd0;
  endtask

  task automatic model_redirect(output logic rd, output logic [31:0] rpc);
    rd = 1'b0;
    if (ex_valid) begin
      if (ex_is_bj) rd = (ex_taken != ex_pred_taken) ||
                         (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
      else          rd = ex_pred_taken;
    end
    rpc = !rd ? 32'd0 : (ex_is_bj && ex_taken) ? ex_target : ex_pc + 32'd4;
  endtask

  task automatic model_update();
    int i;
    bit m;
    i = idx_of(ex_pc);
    m = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
    if (!ex_valid) return;
    if (ex_is_bj) begin
      if (m) begin
        if (ex_taken) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = ex_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (ex_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(ex_pc);
        m_tgt[i]   = ex_target;
        m_ctr[i]   = ex_uncond ? 3 : 2;
      end
    end else if (m) begin
      m_valid[i] = 1'b0;
    end
  endtask

  // One clock: combinational outputs checked mid-low phase, counters after the edge.
  task automatic cycle();
    logic tk, rd;
    logic [31:0] tg, rpc;
    #1;
    model_predict(if_pc, tk, tg);
    tk = tk && if_valid;
    if (!tk) tg = 32'd0;
    model_redirect(rd, rpc);
    chk("pred_taken",  {31'b0, pred_taken}, {31'b0, tk});
    chk("pred_target", pred_target, tg);
    chk("redirect",    {31'b0, redirect}, {31'b0, rd});
    chk("redirect_pc", redirect_pc, rpc);
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      model_update();
      if (if_valid && m_lk != 32'hFFFF_FFFF) m_lk = m_lk + 32'd1;
      if (rd && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 32'd1;
    end
    #1;
    chk("lookup_cnt",  lookup_cnt, m_lk);
    chk("mispred_cnt", mispred_cnt, m_mp);
    @(negedge clk);
  endtask

  task automatic expect_comb(input string tag, input logic ptk, input logic [31:0] ptg,
                             input logic rd, input logic [31:0] rpc);
    #1;
    chk({tag, ".pred_taken"},  {31'b0, pred_taken}, {31'b0, ptk});
    chk({tag, ".pred_target"}, pred_target, ptg);
    chk({tag, ".redirect"},    {31'b0, redirect}, {31'b0, rd});
    chk({tag, ".redirect_pc"}, redirect_pc, rpc);
  endtask

  task automatic drive_if(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic bj, input logic unc,
                          input logic tk, input logic [31:0] tgt, input logic ptk,
                          input logic [31:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_is_bj = bj; ex_uncond = unc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  initial begin
    logic        ptk;
    logic [31:0] ptg, tgts [4];
    tgts[0] = 32'h1C00_0100; tgts[1] = 32'h1C00_0200;
    tgts[2] = 32'h1C00_0304; tgts[3] = 32'h0000_0040;

    resetn = 1'b0;
    drive_if(1'b0, 32'd0);
    drive_ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    model_reset();
    @(negedge clk);
    cycle();
    cycle();
    resetn = 1'b1;

    expect_comb("reset", 1'b0, 32'd0, 1'b0, 32'd0);
    chk("reset.lookup_cnt",  lookup_cnt, 32'd0);
    chk("reset.mispred_cnt", mispred_cnt, 32'd0);

    drive_if(1'b1, 32'h1C00_0000);
    expect_comb("t1", 1'b0, 32'd0, 1'b0, 32'd0);
    cycle();
    chk("t1.lookup_cnt", lookup_cnt, 32'd1);

    drive_if(1'b0, 32'd0);
    drive_ex(1'b1, 32'h1C00_0010, 1'b1, 1'b0, 1'b1, 32'h1C00_0040, 1'b0, 32'd0);
    expect_comb("t2.beq", 1'b0, 32'd0, 1'b1, 32'h1C00_0040);
    cycle();
    chk("t2.mispred_cnt", mispred_cnt, 32'd1);
    drive_ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive_if(1'b1, 32'h1C00_0010);
    expect_comb("t2.lookup", 1'b1, 32'h1C00_0040, 1'b0, 32'd0);
    cycle();

    drive_if(1'b0, 32'd0);
    drive_ex(1'b1, 32'h1C00_0010, 1'b1, 1'b0, 1'b0, 32'h1C00_0040, 1'b1, 32'h1C00_0040);
    expect_comb("t3.nt1", 1'b0, 32'd0, 1'b1, 32'h1C00_0014);
    cycle();
    drive_ex(1'b1, 32'h1C00_0010, 1'b1, 1'b0, 1'b0, 32'h1C00_0040, 1'b0, 32'd0);
    expect_comb("t3.nt2", 1'b0, 32'd0, 1'b0, 32'd0);
    cycle();
    drive_ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive_if(1'b1, 32'h1C00_0010);
    expect_comb("t3.lookup", 1'b0, 32'd0, 1'b0, 32'd0);
    cycle();

    drive_if(1'b1, 32'h1C00_0050);
    expect_comb("t4.alias_miss", 1'b0, 32'd0, 1'b0, 32'd0);
    cycle();
    drive_if(1'b0, 32'd0);
    drive_ex(1'b1, 32'h1C00_0050, 1'b1, 1'b0, 1'b1, 32'h1C00_0100, 1'b0, 32'd0);
    cycle();
    drive_ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive_if(1'b1, 32'h1C00_0010);
    expect_comb("t4.evicted", 1'b0, 32'd0, 1'b0, 32'd0);
    cycle();
    drive_if(1'b1, 32'h1C00_0050);
    expect_comb("t4.new", 1'b1, 32'h1C00_0100, 1'b0, 32'd0);
    cycle();

    drive_if(1'b0, 32'd0);
    drive_ex(1'b1, 32'h1C00_0050, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h1C00_0100);
    expect_comb("t5.nonbr", 1'b0, 32'd0, 1'b1, 32'h1C00_0054);
    cycle();
    drive_ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive_if(1'b1, 32'h1C00_0050);
    expect_comb("t5.invalid", 1'b0, 32'd0, 1'b0, 32'd0);
    cycle();
    drive_if(1'b0, 32'd0);
    drive_ex(1'b1, 32'h1C00_0020, 1'b1, 1'b1, 1'b1, 32'h1C00_0080, 1'b0, 32'd0);
    cycle();
    drive_if(1'b1, 32'h1C00_0020);
    drive_ex(1'b1, 32'h1C00_0020, 1'b1, 1'b1, 1'b1, 32'h1C00_0090, 1'b1, 32'h1C00_0080);
    expect_comb("t5.tgt_old", 1'b1, 32'h1C00_0080, 1'b1, 32'h1C00_0090);
    cycle();
    drive_ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_comb("t5.tgt_new", 1'b1, 32'h1C00_0090, 1'b0, 32'd0);
    cycle();

    for (int n = 0; n < 400; n++) begin
      resetn   = ($urandom_range(0, 99) != 0);
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc    = 32'h1C00_0000 + 32'(4 * $urandom_range(0, 31));
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_pc    = 32'h1C00_0000 + 32'(4 * $urandom_range(0, 31));
      ex_is_bj = ($urandom_range(0, 4) != 0);
      ex_uncond = ex_is_bj && ($urandom_range(0, 3) == 0);
      ex_taken  = ex_uncond || ($urandom_range(0, 1) == 1);
      ex_target = tgts[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) != 0) begin
        model_predict(ex_pc, ptk, ptg);
      end else begin
        ptk = ($urandom_range(0, 1) == 1);
        ptg = tgts[$urandom_range(0, 3)];
      end
      ex_pred_taken  = ptk;
      ex_pred_target = ptg;
      cycle();
    end
    resetn = 1'b1;

    drive_if(1'b0, 32'd0);
    drive_ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    force dut.mispred_cnt_d = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.mispred_cnt_d;
    m_mp = 32'hFFFF_FFFE;
    chk("t6.preload", mispred_cnt, 32'hFFFF_FFFE);
    @(negedge clk);
    drive_ex(1'b1, 32'h1C00_0044, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h1C00_0100);
    cycle();
    chk("t6.sat1", mispred_cnt, 32'hFFFF_FFFF);
    cycle();
    chk("t6.sat2", mispred_cnt, 32'hFFFF_FFFF);

    drive_if(1'b1, 32'h1C00_0030);
    drive_ex(1'b1, 32'h1C00_0030, 1'b1, 1'b1, 1'b1, 32'h1C00_0200, 1'b0, 32'd0);
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    drive_ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("t6.rst_lookup_cnt",  lookup_cnt, 32'd0);
    chk("t6.rst_mispred_cnt", mispred_cnt, 32'd0);
    for (int k = 0; k < 32; k++) begin
      drive_if(1'b1, 32'h1C00_0000 + 32'(4 * k));
      #1;
      chk("t6.rst_miss", {31'b0, pred_taken}, 32'd0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bpu_btb.md
Name: bpu_btb

Overview:
- IF-stage branch predictor: the front-end counterpart of the EX-stage branch resolver.
- IF presents its fetch PC and receives a predicted direction and target in the same cycle.
- EX reports the resolved outcome of each instruction. The block detects mispredictions, drives the fetch redirect, and trains a direct-mapped BTB with 2-bit saturating counters.
- Also keeps lookup and mispredict statistics counters.

Parameters:
- IDX_W, 4: index width; the table has 2^IDX_W entries.
- TAG_W, 26: tag width; must equal 30-IDX_W.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- if_valid  in  1  fetch lookup request this cycle
- if_pc  in  32  fetch PC, word aligned
- pred_taken  out  1  predicted taken for if_pc
- pred_target  out  32  predicted target (0 when pred_taken=0)
- ex_valid  in  1  EX instruction valid this cycle
- ex_pc  in  32  PC of EX instruction
- ex_is_bj  in  1  instruction is of the branch/jump op type
- ex_uncond  in  1  JIRL/B/BL (always taken)
- ex_taken  in  1  resolved taken, from EX branch unit
- ex_target  in  32  resolved target
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction
- ex_pred_target  in  32  predicted target carried down the pipe
- redirect  out  1  mispredict: flush younger instructions and refetch
- redirect_pc  out  32  correct next PC
- lookup_cnt  out  32  number of lookups
- mispred_cnt  out  32  number of mispredicts

Behaviour:
Address fields:
- idx = pc[IDX_W+1:2]
- tag = pc[31:IDX_W+2]

Table entry:
- valid (1), tag (TAG_W), target (32), ctr (2).

Reset (resetn=0 at a clk edge):
- All valid bits cleared and all ctr set to 2'b01.
- lookup_cnt and mispred_cnt cleared to 0.
- Target and tag contents are don't-care.
- The outputs then read pred_taken=0, pred_target=0, redirect=0.
- Reset has priority over a simultaneous update.

Lookup (combinational, zero latency):
- hit = valid[idx] & (tag[idx]==tag(if_pc)).
- pred_taken = if_valid & hit & ctr[idx][1].
- pred_target = target[idx] when pred_taken, else 0.
- Lookup reads pre-edge table contents. There is no bypass from a same-cycle EX update.

Mispredict detection (combinational from EX inputs), with ev = ex_valid:
- ev & ex_is_bj & (ex_taken != ex_pred_taken) -> redirect.
- ev & ex_is_bj & ex_taken & ex_pred_taken & (ex_target != ex_pred_target) -> redirect.
- ev & ~ex_is_bj & ex_pred_taken (alias) -> redirect.
- redirect_pc = (ex_is_bj & ex_taken) ? ex_target : ex_pc+4, modulo 2^32.
- When redirect=0, redirect_pc=0.

Update (at clk edge, ev only), with e = entry at idx(ex_pc) and m = e.valid & tag match:
- Branch, m: ctr saturates up when taken and down when not taken (11 stays 11, 00 stays 00). If taken, target <= ex_target.
- Branch, not m, taken: allocate (overwrite) with valid=1, tag, target=ex_target, ctr = ex_uncond ? 11 : 10.
- Branch, not m, not taken: no change.
- Non-branch with m: invalidate the entry (valid=0).
- ev=0: no table change.

Statistics:
- lookup_cnt += 1 on each cycle with if_valid.
- mispred_cnt += 1 on each cycle with redirect.
- Both counters saturate at 32'hFFFFFFFF and do not wrap.

Simultaneous lookup and update to the same idx:
- The lookup returns old contents.
- The update takes effect the next cycle.

Test Plan:
1. Reset, then if_valid=1, if_pc=0x1C000000 -> pred_taken=0, pred_target=0, lookup_cnt=1 on the next cycle.
2. EX BEQ at 0x1C000010 with ex_taken=1, target 0x1C000040, pred 0 -> redirect=1, redirect_pc=0x1C000040, mispred_cnt=1. Next cycle, lookup 0x1C000010 -> pred_taken=1, pred_target=0x1C000040.
3. Same BEQ resolved not-taken twice -> ctr 10->01->00. First resolution: redirect=1, redirect_pc=0x1C000014. Second, with pred 0: no redirect. Afterwards lookup gives pred_taken=0.
4. Aliasing: 0x1C000050 shares idx with 0x1C000010 under a different tag. Lookup of 0x1C000050 -> miss (pred_taken=0). A taken branch at 0x1C000050 overwrites the entry, and lookup of 0x1C000010 then misses.
5. Non-branch at a hit entry with ex_pred_taken=1 -> redirect=1, redirect_pc=ex_pc+4, entry invalidated. Also: B at 0x1C000020 predicted taken with ex_pred_target 0x1C000080, actual 0x1C000090 -> redirect_pc=0x1C000090 and target updated.
6. Force mispred_cnt to saturate (back door or long run) -> stays 0xFFFFFFFF. Then assert resetn=0 during an active update -> all entries miss and counters read 0.
